store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 81 ++++++++
 tb/tb_store_write_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order write-through store queue with load hazard detection
module store_write_buffer #(
  parameter int          DEPTH     = 4,
  parameter int          XLEN      = 32,
  parameter logic [31:0] MMIO_ADDR = 32'h4000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_st_valid,
  input  logic [31:0]              i_st_addr,
  input  logic [XLEN-1:0]          i_st_data,
  input  logic [XLEN/8-1:0]        i_st_be,
  output logic                     o_st_ready,
  output logic                     o_mem_valid,
  output logic [31:0]              o_mem_addr,
  output logic [XLEN-1:0]          o_mem_data,
  output logic [XLEN/8-1:0]        o_mem_be,
  input  logic                     i_mem_ready,
  input  logic                     i_ld_valid,
  input  logic [31:0]              i_ld_addr,
  output logic                     o_ld_conflict,
  output logic                     o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = XLEN/8;
  logic [29:0]     addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [BW-1:0]   be_q   [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, off;
  logic [CW-1:0]   count_q, count_d;
  logic            accept, enq, deq, hit, ld_mmio;
  assign o_st_ready  = count_q != CW'(DEPTH);
  assign o_mem_valid = count_q != '0;
  assign o_empty     = count_q == '0;
  assign o_count     = count_q;
  assign accept      = i_st_valid && o_st_ready;
  assign enq         = accept && |i_st_be;
  assign deq         = o_mem_valid && i_mem_ready;
  assign o_mem_addr  = {addr_q[rd_q], 2'b00};
  assign o_mem_data  = data_q[rd_q];
  assign o_mem_be    = be_q[rd_q];
  assign ld_mmio     = i_ld_addr >= MMIO_ADDR;
  // Pointer and occupancy next state; power-of-two depth makes pointers wrap naturally
  always_comb begin
    wr_d    = enq ? wr_q + PW'(1) : wr_q;
    rd_d    = deq ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(enq) - CW'(deq);
  end
  // Address match against every live entry (head included even while draining) and the incoming store
  always_comb begin
    off = '0;
    hit = accept && (i_st_addr[31:2] == i_ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if (CW'(off) < count_q && addr_q[i] == i_ld_addr[31:2]) hit = 1'b1;
    end
    o_ld_conflict = i_ld_valid && (ld_mmio ? (o_mem_valid || accept) : hit);
  end
  // Control state, cleared asynchronously so outputs drop as soon as reset asserts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Entry storage is not reset; it is only observed while o_mem_valid is high
  always_ff @(posedge i_clk) begin
    if (enq) begin
      addr_q[wr_q] <= i_st_addr[31:2];
      data_q[wr_q] <= i_st_data;
      be_q[wr_q]   <= i_st_be;
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed and randomized checks against a queue-based model
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] MMIO = 32'h4000_0000;
  logic        clk = 0, rst_n = 0;
  logic        st_valid = 0, mem_ready = 0, ld_valid = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [3:0]  st_be = 0;
  logic        o_st_ready, o_mem_valid, o_ld_conflict, o_empty;
  logic [31:0] o_mem_addr, o_mem_data;
  logic [3:0]  o_mem_be;
  logic [2:0]  o_count;
  int passed = 0, total = 0;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
  ent_t q[$];

  store_write_buffer #(.DEPTH(DEPTH), .XLEN(32), .MMIO_ADDR(MMIO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_st_valid(st_valid), .i_st_addr(st_addr),
    .i_st_data(st_data), .i_st_be(st_be), .o_st_ready(o_st_ready),
    .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_be(o_mem_be), .i_mem_ready(mem_ready), .i_ld_valid(ld_valid),
    .i_ld_addr(ld_addr), .o_ld_conflict(o_ld_conflict), .o_empty(o_empty), .o_count(o_count)
  );

  always #5 clk = ~clk;

  function automatic logic model_conflict();
    logic acc, h;
    acc = st_valid && (q.size() != DEPTH);
    if (!ld_valid) return 1'b0;
    if (ld_addr >= MMIO) return (q.size() != 0) || acc;
    h = acc && (st_addr[31:2] == ld_addr[31:2]);
    foreach (q[i]) if (q[i].a[31:2] == ld_addr[31:2]) h = 1'b1;
    return h;
  endfunction

  task automatic tick();
    logic acc, dq;
    acc = st_valid && (q.size() != DEPTH);
    dq  = (q.size() != 0) && mem_ready;
    @(posedge clk);
    if (dq) q.delete(0);
    if (acc && st_be != 0) q.push_back('{st_addr, st_data, st_be});
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1; st_addr = a; st_data = d; st_be = be;
  endtask

  task automatic test_reset();
    ld_valid = 1; ld_addr = MMIO;
    #3;
    total++; if (o_mem_valid !== 1'b0) $display("FAIL rst_mem_valid got=%b exp=0", o_mem_valid); else passed++;
    total++; if (o_st_ready !== 1'b1) $display("FAIL rst_st_ready got=%b exp=1", o_st_ready); else passed++;
    total++; if (o_empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", o_empty); else passed++;
    total++; if (o_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", o_count); else passed++;
    total++; if (o_ld_conflict !== 1'b0) $display("FAIL rst_conflict got=%b exp=0", o_ld_conflict); else passed++;
    ld_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single();
    mem_ready = 1;
    put(32'h100, 32'hDEAD_BEEF, 4'hF);
    #4;
    total++; if (o_mem_valid !== 1'b0) $display("FAIL single_no_bypass got=%b exp=0", o_mem_valid); else passed++;
    tick();
    st_valid = 0;
    #4;
    total++; if (o_mem_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", o_mem_valid); else passed++;
    total++; if (o_mem_addr !== 32'h100) $display("FAIL single_addr got=%h exp=00000100", o_mem_addr); else passed++;
    total++; if (o_mem_data !== 32'hDEAD_BEEF) $display("FAIL single_data got=%h exp=deadbeef", o_mem_data); else passed++;
    total++; if (o_mem_be !== 4'hF) $display("FAIL single_be got=%h exp=f", o_mem_be); else passed++;
    tick();
    #4;
    total++; if (o_empty !== 1'b1) $display("FAIL single_empty got=%b exp=1", o_empty); else passed++;
    tick();
  endtask

  task automatic test_fill();
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      put(32'h1000 + 32'(4*i) + 32'(i%4), 32'(i), 4'hF);
      #4;
      total++; if (o_st_ready !== (i < 4)) $display("FAIL fill_ready i=%0d got=%b exp=%b", i, o_st_ready, i < 4); else passed++;
      tick();
    end
    st_valid = 0;
    #4;
    total++; if (o_count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", o_count); else passed++;
    total++; if (o_st_ready !== 1'b0) $display("FAIL fill_full_ready got=%b exp=0", o_st_ready); else passed++;
    tick();
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      total++; if (o_mem_data !== 32'(i)) $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, o_mem_data, i); else passed++;
      total++; if (o_mem_addr !== 32'h1000 + 32'(4*i)) $display("FAIL drain_addr i=%0d got=%h exp=%h", i, o_mem_addr, 32'h1000 + 32'(4*i)); else passed++;
      total++; if (o_st_ready !== (i != 0)) $display("FAIL drain_ready i=%0d got=%b exp=%b", i, o_st_ready, i != 0); else passed++;
      tick();
    end
    #4;
    total++; if (o_empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", o_empty); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      put(32'h2000 + 32'(4*i), 32'h50 + 32'(i), 4'hF);
      tick();
    end
    mem_ready = 1;
    for (int k = 0; k < 11; k++) begin
      st_valid = k < 8; st_addr = 32'h2100 + 32'(4*k); st_data = 32'h100 + 32'(k);
      #4;
      total++; if (o_mem_data !== (k < 3 ? 32'h50 + 32'(k) : 32'h100 + 32'(k-3)))
        $display("FAIL b2b_data k=%0d got=%h exp=%h", k, o_mem_data, k < 3 ? 32'h50 + 32'(k) : 32'h100 + 32'(k-3)); else passed++;
      if (k < 8) begin
        total++; if (o_count !== 3'd3) $display("FAIL b2b_count k=%0d got=%0d exp=3", k, o_count); else passed++;
      end
      tick();
    end
    st_valid = 0;
    #4;
    total++; if (o_empty !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", o_empty); else passed++;
    tick();
  endtask

  task automatic test_hazard();
    mem_ready = 0;
    put(32'h204, 32'h11, 4'b0001);
    tick();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h206;
    #4;
    total++; if (o_ld_conflict !== 1'b1) $display("FAIL haz_same_word got=%b exp=1", o_ld_conflict); else passed++;
    tick();
    ld_addr = 32'h208;
    #4;
    total++; if (o_ld_conflict !== 1'b0) $display("FAIL haz_other_word got=%b exp=0", o_ld_conflict); else passed++;
    tick();
    ld_addr = MMIO;
    #4;
    total++; if (o_ld_conflict !== 1'b1) $display("FAIL haz_mmio got=%b exp=1", o_ld_conflict); else passed++;
    total++; if (o_count !== 3'd1) $display("FAIL haz_count got=%0d exp=1", o_count); else passed++;
    tick();
    put(32'h30C, 32'h22, 4'hF); ld_addr = 32'h30E;
    #4;
    total++; if (o_ld_conflict !== 1'b1) $display("FAIL haz_incoming got=%b exp=1", o_ld_conflict); else passed++;
    tick();
    st_valid = 0; mem_ready = 1; ld_addr = 32'h204;
    #4;
    total++; if (o_ld_conflict !== 1'b1) $display("FAIL haz_head_draining got=%b exp=1", o_ld_conflict); else passed++;
    tick();
    ld_valid = 0;
    tick();
  endtask

  task automatic test_zero_be_reset();
    mem_ready = 0;
    put(32'h500, 32'h33, 4'h0);
    #4;
    total++; if (o_st_ready !== 1'b1) $display("FAIL zbe_ready got=%b exp=1", o_st_ready); else passed++;
    tick();
    st_valid = 0;
    #4;
    total++; if (o_count !== 3'd0) $display("FAIL zbe_count got=%0d exp=0", o_count); else passed++;
    tick();
    put(32'h700, 32'h44, 4'hF); tick();
    put(32'h704, 32'h55, 4'hF); tick();
    st_valid = 0; mem_ready = 1; ld_valid = 1; ld_addr = MMIO;
    #4;
    total++; if (o_count !== 3'd2) $display("FAIL prerst_count got=%0d exp=2", o_count); else passed++;
    rst_n = 0;
    #1;
    total++; if (o_mem_valid !== 1'b0) $display("FAIL arst_mem_valid got=%b exp=0", o_mem_valid); else passed++;
    total++; if (o_st_ready !== 1'b1) $display("FAIL arst_ready got=%b exp=1", o_st_ready); else passed++;
    total++; if (o_empty !== 1'b1) $display("FAIL arst_empty got=%b exp=1", o_empty); else passed++;
    total++; if (o_count !== 3'd0) $display("FAIL arst_count got=%0d exp=0", o_count); else passed++;
    total++; if (o_ld_conflict !== 1'b0) $display("FAIL arst_conflict got=%b exp=0", o_ld_conflict); else passed++;
    @(posedge clk); #1;
    q.delete();
    rst_n = 1; ld_valid = 0; mem_ready = 0;
    put(32'h600, 32'hABCD_0123, 4'hF);
    tick();
    st_valid = 0;
    #4;
    total++; if (o_mem_data !== 32'hABCD_0123) $display("FAIL postrst_data got=%h exp=abcd0123", o_mem_data); else passed++;
    total++; if (dut.rd_q !== 2'd0) $display("FAIL postrst_head_idx got=%0d exp=0", dut.rd_q); else passed++;
    total++; if (o_count !== 3'd1) $display("FAIL postrst_count got=%0d exp=1", o_count); else passed++;
    tick();
    mem_ready = 1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'h800, 32'h804, 32'h80C, MMIO + 32'h10};
    for (int c = 0; c < 400; c++) begin
      st_valid  = $urandom_range(0, 1) == 1;
      st_addr   = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      st_data   = $urandom;
      st_be     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      mem_ready = $urandom_range(0, 2) == 0;
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_addr   = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      #4;
      total++; if (o_count !== 3'(q.size())) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, o_count, q.size()); else passed++;
      total++; if (o_st_ready !== (q.size() != DEPTH)) $display("FAIL rnd_ready c=%0d got=%b", c, o_st_ready); else passed++;
      total++; if (o_mem_valid !== (q.size() != 0)) $display("FAIL rnd_valid c=%0d got=%b", c, o_mem_valid); else passed++;
      total++; if (o_ld_conflict !== model_conflict()) $display("FAIL rnd_conflict c=%0d got=%b exp=%b", c, o_ld_conflict, model_conflict()); else passed++;
      if (q.size() != 0) begin
        total++; if ({o_mem_addr, o_mem_data, o_mem_be} !== {q[0].a[31:2], 2'b00, q[0].d, q[0].be})
          $display("FAIL rnd_head c=%0d got=%h/%h/%h exp=%h/%h/%h", c, o_mem_addr, o_mem_data, o_mem_be, {q[0].a[31:2], 2'b00}, q[0].d, q[0].be); else passed++;
      end
      tick();
    end
    st_valid = 0; ld_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_zero_be_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
